demux_1to2_stream: RTL and testbench
====================================

// Module: demux_1to2_stream
//
// PURPOSE
//   Registered 1-to-2 stream demultiplexer: routes each input beat to output A or B.
//   Valid/ready handshake on all sides, optional packet locking via last_i.
//   Each output has a one-entry register slice, giving full throughput.
//   Fans one producer out to two consumers; inverse of the 2:1 data mux.
//
// PARAMETERS
//   BIT_WIDTH  8   data width of input and both outputs
//   CNT_WIDTH  16  width of per-output beat counters (used only with DEMUX_STATS_EN)
//
// PORTS
//   clk_i      in   1          clock, rising edge
//   rst_ni     in   1          asynchronous reset, active low
//   sel_i      in   1          route for the current beat: 0 -> A, 1 -> B (sampled only in IDLE)
//   valid_i    in   1          input beat valid
//   ready_o    out  1          input beat can be accepted
//   data_i     in   BIT_WIDTH  input data
//   last_i     in   1          input beat is the last beat of its packet
//   a_valid_o  out  1          A beat valid;  a_ready_i  in  1  A consumer ready
//   a_data_o   out  BIT_WIDTH  A data;        a_last_o   out 1  A last flag
//   b_valid_o  out  1          B beat valid;  b_ready_i  in  1  B consumer ready
//   b_data_o   out  BIT_WIDTH  B data;        b_last_o   out 1  B last flag
//   a_count_o  out  CNT_WIDTH  A handshakes (only with DEMUX_STATS_EN)
//   b_count_o  out  CNT_WIDTH  B handshakes (only with DEMUX_STATS_EN)
//
// BEHAVIOUR
//   - Reset (rst_ni low, async): all *_valid_o, *_data_o and *_last_o = 0, FSM = IDLE, counters = 0.
//   - Route: in IDLE use sel_i; in LOCK_A/LOCK_B use the locked output and ignore sel_i.
//   - Slice x can accept = !x_valid_q | x_ready_i.
//   - ready_o = can-accept of the routed slice. It is combinational from sel_i, state and x_ready_i.
//   - ready_o does not depend on valid_i.
//   - Accept when valid_i & ready_o. The beat appears on x_*_o the next cycle (latency 1).
//   - Back-to-back beats sustain 1 beat/cycle while the consumer holds ready high.
//   - Output rules: x_valid_o stays high until x_valid_o & x_ready_i.
//   - x_data_o and x_last_o stay stable while x_valid_o & !x_ready_i.
//   - The non-routed slice keeps draining independently. A and B may handshake in the same cycle.
//   - FSM IDLE:
//     - accept with last_i=0 -> LOCK_A when sel_i=0, LOCK_B when sel_i=1.
//     - accept with last_i=1 -> stay in IDLE (single-beat packet).
//   - FSM LOCK_x: accept with last_i=1 -> IDLE; otherwise stay in LOCK_x.
//   - A change of sel_i mid-packet has no effect.
//   - Routed slice full and its consumer stalled: ready_o=0 and the input stalls. The other slice is unaffected.
//   - Reset mid-packet: in-flight beats are discarded and the FSM returns to IDLE.
//   - data_i and last_i are don't-care while valid_i=0.
//
// CONFIGURATION
//   DEMUX_STATS_EN defined:
//     - a_count_o and b_count_o exist.
//     - Each increments by 1 on its output handshake and wraps 2^CNT_WIDTH-1 -> 0.
//     - Both reset to 0.
//   DEMUX_STATS_EN undefined: count ports and logic are absent. Datapath timing is identical.
//
// STRUCTURE
//   - demux_pkg:
//     - typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} demux_state_e.
//     - typedef enum logic {ROUTE_A, ROUTE_B} demux_route_e.
//   - Sub-module demux_out_slice #(BIT_WIDTH): one-entry valid/ready register for data and last.
//     - Ports: clk_i, rst_ni, in valid/ready/data/last, out valid/ready/data/last.
//     - Instantiated twice, as u_slice_a and u_slice_b.
//   - Top level holds the FSM, the route/ready mux and the optional counters.
//
// TESTING
//   - Reset: rst_ni low with valid_i=1 -> all outputs 0, ready_o follows can-accept.
//     After release, first beat 0xA5 with sel_i=0, last_i=1 -> a_data_o=0xA5 next cycle.
//   - Streaming: 16 beats 0x00..0x0F, sel_i=1, last_i=1 each, b_ready_i=1.
//     -> B shows 0x00..0x0F in 16 consecutive cycles, a_valid_o stays 0.
//   - Packet lock: sel_i=0 with last_i=0 on beat 0x11, then sel_i toggles on 0x22 and 0x33 (last_i=1 on 0x33).
//     -> all three beats go to A, a_last_o=1 only on 0x33, FSM returns to IDLE.
//   - Backpressure: a_ready_i=0 with A full and sel_i=0 -> ready_o=0 and a_data_o held stable.
//     Switch to sel_i=1 in IDLE -> B accepts at once.
//   - Parallel drain: both slices full, then a_ready_i=b_ready_i=1 -> both handshake in the same cycle.
//   - Reset mid-packet: rst_ni pulses low while in LOCK_B -> valids drop to 0 and the next beat routes by sel_i.
//     With DEMUX_STATS_EN and CNT_WIDTH=4: 17 A handshakes -> a_count_o=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } demux_state_e;

    typedef enum logic {
        ROUTE_A = 1'b0,
        ROUTE_B = 1'b1
    } demux_route_e;

endpackage : demux_pkg

// File: rtl/demux_out_slice.sv
// One-entry valid/ready register slice carrying data and a last flag.
module demux_out_slice #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [BIT_WIDTH-1:0] in_data_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [BIT_WIDTH-1:0] out_data_o,
    output logic                 out_last_o
);

    logic                 valid_q, valid_d;
    logic [BIT_WIDTH-1:0] data_q,  data_d;
    logic                 last_q,  last_d;

    // Empty, or the held beat leaves this cycle: a new beat may enter.
    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            last_d  = in_last_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule : demux_out_slice

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demux with packet locking on last_i.
// Optional per-output handshake counters when DEMUX_STATS_EN is defined.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 8
`ifdef DEMUX_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sel_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [BIT_WIDTH-1:0] data_i,
    input  logic                 last_i,
    output logic                 a_valid_o,
    input  logic                 a_ready_i,
    output logic [BIT_WIDTH-1:0] a_data_o,
    output logic                 a_last_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [BIT_WIDTH-1:0] b_data_o,
    output logic                 b_last_o
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] a_count_o,
    output logic [CNT_WIDTH-1:0] b_count_o
`endif
);

    demux_state_e state_q, state_d;
    demux_route_e route;
    logic         a_in_ready, b_in_ready;
    logic         accept;

    // While a packet is open the locked output wins over sel_i.
    always_comb begin
        route = demux_route_e'(sel_i);
        if (state_q == LOCK_A) route = ROUTE_A;
        if (state_q == LOCK_B) route = ROUTE_B;
    end

    assign ready_o = (route == ROUTE_B) ? b_in_ready : a_in_ready;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (last_i) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = (route == ROUTE_B) ? LOCK_B : LOCK_A;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    demux_out_slice #(.BIT_WIDTH(BIT_WIDTH)) u_slice_a (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (valid_i && (route == ROUTE_A)),
        .in_ready_o  (a_in_ready),
        .in_data_i   (data_i),
        .in_last_i   (last_i),
        .out_valid_o (a_valid_o),
        .out_ready_i (a_ready_i),
        .out_data_o  (a_data_o),
        .out_last_o  (a_last_o)
    );

    demux_out_slice #(.BIT_WIDTH(BIT_WIDTH)) u_slice_b (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (valid_i && (route == ROUTE_B)),
        .in_ready_o  (b_in_ready),
        .in_data_i   (data_i),
        .in_last_i   (last_i),
        .out_valid_o (b_valid_o),
        .out_ready_i (b_ready_i),
        .out_data_o  (b_data_o),
        .out_last_o  (b_last_o)
    );

`ifdef DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] a_count_q, a_count_d;
    logic [CNT_WIDTH-1:0] b_count_q, b_count_d;

    // Free-running handshake counters; wrap naturally at 2^CNT_WIDTH.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_valid_o && a_ready_i) a_count_d = a_count_q + CNT_WIDTH'(1);
        if (b_valid_o && b_ready_i) b_count_d = b_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count_o = a_count_q;
    assign b_count_o = b_count_q;
`endif

endmodule : demux_1to2_stream

// File: tb/tb_demux_1to2_stream.sv
// Scoreboard bench for demux_1to2_stream: stimulus pushes expected beats, a monitor pops on handshakes.
module tb_demux_1to2_stream;

    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         sel_i, valid_i, last_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         a_valid_o, a_ready_i, a_last_o;
    logic [W-1:0] a_data_o;
    logic         b_valid_o, b_ready_i, b_last_o;
    logic [W-1:0] b_data_o;
`ifdef DEMUX_STATS_EN
    logic [3:0]   a_count_o, b_count_o;
`endif

    int tests = 0;
    int fails = 0;
    logic [W:0] exp_a[$];
    logic [W:0] exp_b[$];
    int lock_m = 0;  // model FSM: 0 idle, 1 locked to A, 2 locked to B

    always #5 clk_i = ~clk_i;

    demux_1to2_stream #(
        .BIT_WIDTH(W)
`ifdef DEMUX_STATS_EN
        , .CNT_WIDTH(4)
`endif
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sel_i     (sel_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .last_i    (last_i),
        .a_valid_o (a_valid_o),
        .a_ready_i (a_ready_i),
        .a_data_o  (a_data_o),
        .a_last_o  (a_last_o),
        .b_valid_o (b_valid_o),
        .b_ready_i (b_ready_i),
        .b_data_o  (b_data_o),
        .b_last_o  (b_last_o)
`ifdef DEMUX_STATS_EN
        , .a_count_o (a_count_o)
        , .b_count_o (b_count_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: every handshake must match the head of its expectation queue.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (a_valid_o && a_ready_i) begin
                if (exp_a.size() == 0) chk("a_unexpected_beat", {23'd0, a_last_o, a_data_o}, 32'hFFFF_FFFF);
                else chk("a_beat", {23'd0, a_last_o, a_data_o}, {23'd0, exp_a.pop_front()});
            end
            if (b_valid_o && b_ready_i) begin
                if (exp_b.size() == 0) chk("b_unexpected_beat", {23'd0, b_last_o, b_data_o}, 32'hFFFF_FFFF);
                else chk("b_beat", {23'd0, b_last_o, b_data_o}, {23'd0, exp_b.pop_front()});
            end
        end
    end

    // Offer one beat, wait (bounded) for acceptance; valid_i stays high for back-to-back use.
    task automatic send(input logic sel, input logic [W-1:0] d, input logic last);
        int route;
        bit ok = 0;
        sel_i   = sel;
        data_i  = d;
        last_i  = last;
        valid_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (ready_o) begin ok = 1; break; end
            @(posedge clk_i); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            valid_i = 1'b0;
            return;
        end
        route = (lock_m == 0) ? int'(sel) : lock_m - 1;
        if (route == 0) exp_a.push_back({last, d});
        else            exp_b.push_back({last, d});
        lock_m = last ? 0 : route + 1;
        @(posedge clk_i); #1;
    endtask

    task automatic idle_cycles(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_a.delete();
        exp_b.delete();
        lock_m = 0;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b1; sel_i = 1'b0; data_i = 8'h5A; last_i = 1'b0;
        a_ready_i = 1'b0; b_ready_i = 1'b0;

        // Reset state with valid_i asserted
        @(negedge clk_i);
        chk("rst_a_valid", 32'(a_valid_o), 32'd0);
        chk("rst_b_valid", 32'(b_valid_o), 32'd0);
        chk("rst_a_data",  32'(a_data_o),  32'd0);
        chk("rst_b_data",  32'(b_data_o),  32'd0);
        chk("rst_a_last",  32'(a_last_o),  32'd0);
        chk("rst_b_last",  32'(b_last_o),  32'd0);
        chk("rst_ready",   32'(ready_o),   32'd1);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        a_ready_i = 1'b1; b_ready_i = 1'b1;
        @(posedge clk_i); #1;

        // First beat, latency 1
        send(1'b0, 8'hA5, 1'b1);
        valid_i = 1'b0;
        chk("first_a_valid", 32'(a_valid_o), 32'd1);
        chk("first_a_data",  32'(a_data_o),  32'hA5);
        idle_cycles(2);

        // Streaming 16 beats to B at full rate
        for (int i = 0; i < 16; i++) send(1'b1, W'(i), 1'b1);
        chk("stream_b_valid_after", 32'(b_valid_o), 32'd1);
        idle_cycles(3);

        // Packet lock: sel_i changes mid-packet are ignored
        send(1'b0, 8'h11, 1'b0);
        send(1'b1, 8'h22, 1'b0);
        send(1'b1, 8'h33, 1'b1);
        send(1'b1, 8'h3C, 1'b1);  // back in IDLE, so this one routes to B
        idle_cycles(3);

        // Backpressure on A
        a_ready_i = 1'b0;
        send(1'b0, 8'h44, 1'b1);
        sel_i = 1'b0; data_i = 8'h55; last_i = 1'b1; valid_i = 1'b1;
        @(negedge clk_i);
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        chk("bp_a_data", 32'(a_data_o), 32'h44);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("bp_a_data_held", 32'(a_data_o), 32'h44);
        chk("bp_a_valid_held", 32'(a_valid_o), 32'd1);
        @(posedge clk_i); #1;
        sel_i = 1'b1;
        #1;
        chk("bp_b_ready", 32'(ready_o), 32'd1);
        send(1'b1, 8'h66, 1'b1);
        idle_cycles(1);

        // Parallel drain: fill B while A is still held, then release both
        b_ready_i = 1'b0;
        send(1'b1, 8'h77, 1'b1);
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("pd_both_full", 32'({a_valid_o, b_valid_o}), 32'd3);
        @(posedge clk_i); #1;
        a_ready_i = 1'b1; b_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("pd_both_drained", 32'({a_valid_o, b_valid_o}), 32'd0);

        // Reset while locked to B with a beat in flight
        b_ready_i = 1'b0;
        send(1'b1, 8'h88, 1'b0);
        valid_i = 1'b0;
        chk("mid_b_valid", 32'(b_valid_o), 32'd1);
        do_reset();
        #1;
        chk("mid_rst_valids", 32'({a_valid_o, b_valid_o}), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; b_ready_i = 1'b1;
        @(posedge clk_i); #1;
        send(1'b0, 8'h99, 1'b1);  // must follow sel_i to A, not stay on B
        idle_cycles(3);

`ifdef DEMUX_STATS_EN
        do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 17; i++) send(1'b0, W'(8'hC0 + i), 1'b1);
        idle_cycles(3);
        chk("a_count_wrap", 32'(a_count_o), 32'd1);
        chk("b_count_zero", 32'(b_count_o), 32'd0);
`endif

        chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_demux_1to2_stream
